// File: rtl/spi_slave_sync.sv
// spi_slave_sync: mode-0 SPI responder, fully oversampled on mclk.
// Optional sticky overrun flag when SPI_SLV_OVERRUN_EN is defined.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  input  logic              read,
  output logic              busy
`ifdef SPI_SLV_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [DATA_W-1:0]      hold_q;
  logic [DATA_W-1:0]      shift_tx_q;
  logic [DATA_W-1:0]      shift_rx_q;
  logic [DATA_W-1:0]      data_out_q;
  logic [DATA_W-1:0]      tx_word_d;
  logic [CW-1:0]          bit_cnt_q;
  logic                   miso_q;
  logic                   tx_ready_q;
  logic                   rx_valid_q;
`ifdef SPI_SLV_OVERRUN_EN
  logic                   ovr_q;
`endif

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_bit;
  logic word_done;
  logic preload;

  // cs sync resets low so a cs held low through reset never opens a frame
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];
  assign cs_rise   = cs_q[SYNC_STAGES-2] & ~cs_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_q[SYNC_STAGES-2] & cs_q[SYNC_STAGES-1];
  assign mosi_bit  = mosi_q[SYNC_STAGES-1];

  assign word_done = (bit_cnt_q == CW'(DATA_W));
  assign tx_word_d = tx_ready_q ? '0 : hold_q;
  assign preload   = (state_q == LOAD) |
                     ((state_q == SHIFT) & ~cs_rise & word_done);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      data_out_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
      ovr_q      <= 1'b0;
`endif
    end else begin
      if (read && rx_valid_q) begin
        rx_valid_q <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
        ovr_q      <= 1'b0;
`endif
      end
      if (load && tx_ready_q && !preload) begin
        hold_q     <= data_in;
        tx_ready_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall) state_q <= LOAD;
        end
        LOAD: begin
          shift_tx_q <= tx_word_d;
          miso_q     <= first_bit(tx_word_d);
          tx_ready_q <= 1'b1;
          bit_cnt_q  <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          if (word_done) begin
            data_out_q <= shift_rx_q;
            rx_valid_q <= 1'b1;
`ifdef SPI_SLV_OVERRUN_EN
            if (rx_valid_q && !read) ovr_q <= 1'b1;
`endif
          end
          if (cs_rise) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (word_done) begin
            shift_tx_q <= tx_word_d;
            miso_q     <= first_bit(tx_word_d);
            tx_ready_q <= 1'b1;
            bit_cnt_q  <= '0;
          end else if (sclk_rise) begin
            if (MSB_FIRST)
              shift_rx_q <= {shift_rx_q[DATA_W-2:0], mosi_bit};
            else
              shift_rx_q <= {mosi_bit, shift_rx_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (sclk_fall && bit_cnt_q != '0) begin
            // the fall after the last bit lands after preload and is skipped
            if (MSB_FIRST) begin
              shift_tx_q <= shift_tx_q << 1;
              miso_q     <= shift_tx_q[DATA_W-2];
            end else begin
              shift_tx_q <= shift_tx_q >> 1;
              miso_q     <= shift_tx_q[1];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign data_out = data_out_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
`ifdef SPI_SLV_OVERRUN_EN
  assign overrun  = ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: self-checking bench for spi_slave_sync.
// Random master frames checked against a word-level model.
module tb_spi_slave_sync;
  localparam int W = 8;
  localparam int H = 4;

  logic         mclk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic         load;
  logic [W-1:0] data_in;
  logic         tx_ready;
  logic [W-1:0] data_out;
  logic         rx_valid;
  logic         read;
  logic         busy;
`ifdef SPI_SLV_OVERRUN_EN
  logic         overrun;
`endif

  spi_slave_sync #(
    .DATA_W(W),
    .SYNC_STAGES(2),
    .MSB_FIRST(1'b1)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .sclk(sclk),
    .cs(cs),
    .mosi(mosi),
    .miso(miso),
    .load(load),
    .data_in(data_in),
    .tx_ready(tx_ready),
    .data_out(data_out),
    .rx_valid(rx_valid),
    .read(read),
    .busy(busy)
`ifdef SPI_SLV_OVERRUN_EN
    ,
    .overrun(overrun)
`endif
  );

  always #5 mclk = ~mclk;

  int n_chk  = 0;
  int n_pass = 0;

  bit           m_full;
  logic [W-1:0] m_hold;
  logic [W-1:0] m_dout;
  bit           m_valid;
  bit           m_ovr;

  logic [W-1:0] mtx [4];
  logic [W-1:0] mrx [4];
  logic [W-1:0] mexp[4];

  task automatic model_reset();
    m_full  = 0;
    m_hold  = '0;
    m_dout  = '0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  task automatic xfer_word(input logic [W-1:0] t,
                           output logic [W-1:0] r);
    for (int i = W - 1; i >= 0; i--) begin
      mosi = t[i];
      repeat (H) @(negedge mclk);
      r[i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge mclk);
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input int n);
    cs = 1'b0;
    repeat (4) @(negedge mclk);
    for (int k = 0; k < n; k++) begin
      mexp[k] = m_full ? m_hold : '0;
      m_full  = 0;
      xfer_word(mtx[k], mrx[k]);
      if (m_valid) m_ovr = 1;
      m_dout  = mtx[k];
      m_valid = 1;
    end
    mosi = 1'b0;
    repeat (H) @(negedge mclk);
    cs = 1'b1;
    repeat (6) @(negedge mclk);
  endtask

  task automatic do_load(input logic [W-1:0] d);
    load    = 1'b1;
    data_in = d;
    @(negedge mclk);
    load = 1'b0;
    if (!m_full) begin
      m_full = 1;
      m_hold = d;
    end
  endtask

  task automatic do_read();
    read = 1'b1;
    @(negedge mclk);
    read = 1'b0;
    if (m_valid) begin
      m_valid = 0;
      m_ovr   = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (miso !== 1'b0) $display("FAIL rst_miso: got %b want 0", miso);
    else n_pass++;
    n_chk++;
    if (tx_ready !== 1'b1) $display("FAIL rst_txr: got %b want 1", tx_ready);
    else n_pass++;
    n_chk++;
    if (data_out !== '0) $display("FAIL rst_dout: got %h want 00", data_out);
    else n_pass++;
    n_chk++;
    if (rx_valid !== 1'b0) $display("FAIL rst_rxv: got %b want 0", rx_valid);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
`ifdef SPI_SLV_OVERRUN_EN
    n_chk++;
    if (overrun !== 1'b0) $display("FAIL rst_ovr: got %b want 0", overrun);
    else n_pass++;
`endif
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    repeat (4) @(negedge mclk);
  endtask

  task automatic test_basic();
    do_load(8'hA5);
    n_chk++;
    if (tx_ready !== 1'b0) $display("FAIL load_txr: got %b want 0", tx_ready);
    else n_pass++;
    mtx[0] = 8'h3C;
    do_frame(1);
    n_chk++;
    if (mrx[0] !== mexp[0]) $display("FAIL basic_miso: got %h want %h", mrx[0], mexp[0]);
    else n_pass++;
    n_chk++;
    if (data_out !== m_dout) $display("FAIL basic_dout: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (rx_valid !== m_valid) $display("FAIL basic_rxv: got %b want %b", rx_valid, m_valid);
    else n_pass++;
    n_chk++;
    if (tx_ready !== 1'b1) $display("FAIL basic_txr: got %b want 1", tx_ready);
    else n_pass++;
  endtask

  task automatic test_no_load();
    do_read();
    mtx[0] = 8'hFF;
    do_frame(1);
    n_chk++;
    if (mrx[0] !== mexp[0]) $display("FAIL noload_miso: got %h want %h", mrx[0], mexp[0]);
    else n_pass++;
    n_chk++;
    if (data_out !== m_dout) $display("FAIL noload_dout: got %h want %h", data_out, m_dout);
    else n_pass++;
  endtask

  task automatic test_ignored_load();
    do_read();
    do_load(8'h11);
    do_load(8'h22);
    mtx[0] = W'($urandom);
    mtx[1] = W'($urandom);
    do_frame(2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (mrx[k] !== mexp[k]) $display("FAIL ign_miso%0d: got %h want %h", k, mrx[k], mexp[k]);
      else n_pass++;
    end
    n_chk++;
    if (data_out !== m_dout) $display("FAIL ign_dout: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (tx_ready !== 1'b1) $display("FAIL ign_txr: got %b want 1", tx_ready);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_read();
    mtx[0] = 8'h81;
    mtx[1] = 8'h42;
    do_frame(2);
    n_chk++;
    if (data_out !== m_dout) $display("FAIL ovr_dout: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (rx_valid !== m_valid) $display("FAIL ovr_rxv: got %b want %b", rx_valid, m_valid);
    else n_pass++;
`ifdef SPI_SLV_OVERRUN_EN
    n_chk++;
    if (overrun !== m_ovr) $display("FAIL ovr_flag: got %b want %b", overrun, m_ovr);
    else n_pass++;
`endif
    do_read();
    n_chk++;
    if (rx_valid !== m_valid) $display("FAIL ovr_read_rxv: got %b want %b", rx_valid, m_valid);
    else n_pass++;
`ifdef SPI_SLV_OVERRUN_EN
    n_chk++;
    if (overrun !== m_ovr) $display("FAIL ovr_read_flag: got %b want %b", overrun, m_ovr);
    else n_pass++;
`endif
  endtask

  task automatic test_abort();
    logic [W-1:0] t;
    logic [W-1:0] r;
    do_read();
    do_load(W'($urandom));
    t  = 8'hF0;
    cs = 1'b0;
    repeat (4) @(negedge mclk);
    m_full = 0;
    for (int i = W - 1; i >= W - 5; i--) begin
      mosi = t[i];
      repeat (H) @(negedge mclk);
      r[i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge mclk);
      sclk = 1'b0;
    end
    n_chk++;
    if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy);
    else n_pass++;
    repeat (H) @(negedge mclk);
    cs = 1'b1;
    repeat (6) @(negedge mclk);
    n_chk++;
    if (rx_valid !== m_valid) $display("FAIL abort_rxv: got %b want %b", rx_valid, m_valid);
    else n_pass++;
    n_chk++;
    if (data_out !== m_dout) $display("FAIL abort_dout: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (miso !== 1'b0) $display("FAIL abort_miso: got %b want 0", miso);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", busy);
    else n_pass++;
    mtx[0] = 8'h0F;
    do_frame(1);
    n_chk++;
    if (data_out !== m_dout) $display("FAIL abort_next: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (mrx[0] !== mexp[0]) $display("FAIL abort_lost: got %h want %h", mrx[0], mexp[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] t;
    logic [W-1:0] r;
    do_load(W'($urandom));
    t  = W'($urandom);
    cs = 1'b0;
    repeat (4) @(negedge mclk);
    for (int i = W - 1; i >= W - 3; i--) begin
      mosi = t[i];
      repeat (H) @(negedge mclk);
      r[i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge mclk);
      sclk = 1'b0;
    end
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({miso, tx_ready, rx_valid, busy} !== 4'b0100)
      $display("FAIL midrst_flags: got %b want 0100", {miso, tx_ready, rx_valid, busy});
    else n_pass++;
    n_chk++;
    if (data_out !== '0) $display("FAIL midrst_dout: got %h want 00", data_out);
    else n_pass++;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
    repeat (2) @(negedge mclk);
    cs = 1'b1;
    repeat (6) @(negedge mclk);
    mtx[0] = 8'h5A;
    do_frame(1);
    n_chk++;
    if (data_out !== m_dout) $display("FAIL midrst_next: got %h want %h", data_out, m_dout);
    else n_pass++;
    n_chk++;
    if (mrx[0] !== mexp[0]) $display("FAIL midrst_miso: got %h want %h", mrx[0], mexp[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1, 0) == 1) do_read();
      if ($urandom_range(2, 0) != 0) do_load(W'($urandom));
      n = $urandom_range(3, 1);
      for (int k = 0; k < n; k++) mtx[k] = W'($urandom);
      do_frame(n);
      for (int k = 0; k < n; k++) begin
        n_chk++;
        if (mrx[k] !== mexp[k])
          $display("FAIL rnd%0d_miso%0d: got %h want %h", it, k, mrx[k], mexp[k]);
        else n_pass++;
      end
      n_chk++;
      if (data_out !== m_dout) $display("FAIL rnd%0d_dout: got %h want %h", it, data_out, m_dout);
      else n_pass++;
      n_chk++;
      if ({rx_valid, tx_ready, busy} !== {m_valid, ~m_full, 1'b0})
        $display("FAIL rnd%0d_flags: got %b want %b", it,
                 {rx_valid, tx_ready, busy}, {m_valid, ~m_full, 1'b0});
      else n_pass++;
`ifdef SPI_SLV_OVERRUN_EN
      n_chk++;
      if (overrun !== m_ovr) $display("FAIL rnd%0d_ovr: got %b want %b", it, overrun, m_ovr);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    reset   = 1'b1;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    load    = 1'b0;
    read    = 1'b0;
    data_in = '0;
    @(negedge mclk);
    test_reset();
    test_basic();
    test_no_load();
    test_ignored_load();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
